// File: rtl/id_decode_buffer.sv
// RV32I decode stage: combinational decode of the fetched word feeding a
// registered two-entry skid buffer (main drives outputs, skid absorbs one stall).

package pcmux;
  typedef enum logic [1:0] {
    pc_plus4 = 2'b00,
    alu_out  = 2'b01,
    alu_mod2 = 2'b10
  } pcmux_sel_t;
endpackage

package alumux;
  typedef enum logic {
    rs1_out = 1'b0,
    pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    i_imm   = 3'b000,
    u_imm   = 3'b001,
    b_imm   = 3'b010,
    s_imm   = 3'b011,
    j_imm   = 3'b100,
    rs2_out = 3'b101
  } alumux2_sel_t;
endpackage

package cmpmux;
  typedef enum logic {
    rs2_out = 1'b0,
    i_imm   = 1'b1
  } cmpmux_sel_t;
endpackage

package regfilemux;
  typedef enum logic [3:0] {
    alu_out  = 4'b0000,
    br_en    = 4'b0001,
    u_imm    = 4'b0010,
    lw       = 4'b0011,
    pc_plus4 = 4'b0100,
    lb       = 4'b0101,
    lbu      = 4'b0110,
    lh       = 4'b0111,
    lhu      = 4'b1000
  } regfilemux_sel_t;
endpackage

package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    alu_ops                     aluop;
    branch_funct3_t             cmpop;
    alumux::alumux1_sel_t       alumux1_sel;
    alumux::alumux2_sel_t       alumux2_sel;
    cmpmux::cmpmux_sel_t        cmpmux_sel;
    regfilemux::regfilemux_sel_t regfilemux_sel;
    pcmux::pcmux_sel_t          pcmux_sel;
    logic                       load_regfile;
    logic                       mem_read;
    logic                       mem_write;
  } rv32i_control_word;
endpackage

module id_decode_buffer
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  rv32i_word         in_instr,
  input  rv32i_word         in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output rv32i_control_word out_ctrl,
  output rv32i_word         out_pc,
  output rv32i_word         out_imm,
  output rv32i_reg          out_rs1,
  output rv32i_reg          out_rs2,
  output rv32i_reg          out_rd,
  output logic              out_illegal
);

  typedef struct packed {
    rv32i_control_word ctrl;
    rv32i_word         pc;
    rv32i_word         imm;
    rv32i_reg          rs1;
    rv32i_reg          rs2;
    rv32i_reg          rd;
    logic              illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  function automatic bundle_t decode(input rv32i_word instr, input rv32i_word pc);
    bundle_t   b;
    logic [2:0] f3;
    logic      alt;
    logic      is_reg;
    logic      is_shift;
    rv32i_word i_imm;
    rv32i_word s_imm;
    rv32i_word b_imm;
    rv32i_word u_imm;
    rv32i_word j_imm;
    f3       = instr[14:12];
    alt      = instr[30];
    is_reg   = (instr[6:0] == op_reg);
    is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    i_imm = {{20{instr[31]}}, instr[31:20]};
    s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    u_imm = {instr[31:12], 12'h000};
    j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    b     = '0;
    b.pc  = pc;
    b.rs1 = instr[19:15];
    b.rs2 = instr[24:20];
    b.rd  = instr[11:7];
    case (instr[6:0])
      op_lui: begin
        b.ctrl.regfilemux_sel = regfilemux::u_imm;
        b.ctrl.load_regfile   = 1'b1;
        b.imm                 = u_imm;
      end
      op_auipc: begin
        b.ctrl.alumux1_sel    = alumux::pc_out;
        b.ctrl.alumux2_sel    = alumux::u_imm;
        b.ctrl.regfilemux_sel = regfilemux::alu_out;
        b.ctrl.load_regfile   = 1'b1;
        b.imm                 = u_imm;
      end
      op_jal: begin
        b.ctrl.pcmux_sel      = pcmux::alu_out;
        b.ctrl.alumux1_sel    = alumux::pc_out;
        b.ctrl.alumux2_sel    = alumux::j_imm;
        b.ctrl.regfilemux_sel = regfilemux::pc_plus4;
        b.ctrl.load_regfile   = 1'b1;
        b.imm                 = j_imm;
      end
      op_jalr: begin
        b.ctrl.pcmux_sel      = pcmux::alu_mod2;
        b.ctrl.alumux2_sel    = alumux::i_imm;
        b.ctrl.regfilemux_sel = regfilemux::pc_plus4;
        b.ctrl.load_regfile   = 1'b1;
        b.imm                 = i_imm;
      end
      op_br: begin
        b.ctrl.cmpop       = branch_funct3_t'(f3);
        b.ctrl.alumux1_sel = alumux::pc_out;
        b.ctrl.alumux2_sel = alumux::b_imm;
        b.ctrl.aluop       = alu_add;
        b.imm              = b_imm;
      end
      op_load: begin
        b.ctrl.mem_read     = 1'b1;
        b.ctrl.alumux2_sel  = alumux::i_imm;
        b.ctrl.load_regfile = 1'b1;
        b.imm               = i_imm;
        case (f3)
          3'b000:  b.ctrl.regfilemux_sel = regfilemux::lb;
          3'b001:  b.ctrl.regfilemux_sel = regfilemux::lh;
          3'b100:  b.ctrl.regfilemux_sel = regfilemux::lbu;
          3'b101:  b.ctrl.regfilemux_sel = regfilemux::lhu;
          default: b.ctrl.regfilemux_sel = regfilemux::lw;
        endcase
      end
      op_store: begin
        b.ctrl.mem_write   = 1'b1;
        b.ctrl.alumux2_sel = alumux::s_imm;
        b.imm              = s_imm;
      end
      op_imm, op_reg: begin
        b.ctrl.load_regfile = 1'b1;
        b.ctrl.alumux2_sel  = is_reg ? alumux::rs2_out : alumux::i_imm;
        b.ctrl.aluop        = alu_ops'(f3);
        case (f3)
          3'b000: begin
            if (is_reg && alt) b.ctrl.aluop = alu_sub;
          end
          3'b010, 3'b011: begin
            b.ctrl.cmpop          = (f3 == 3'b010) ? blt : bltu;
            b.ctrl.regfilemux_sel = regfilemux::br_en;
            b.ctrl.cmpmux_sel     = is_reg ? cmpmux::rs2_out : cmpmux::i_imm;
          end
          3'b101: b.ctrl.aluop = alt ? alu_sra : alu_srl;
          default: b.ctrl.aluop = alu_ops'(f3);
        endcase
        // Shift-immediates carry only the shamt; the upper bits are funct7.
        if (is_reg) b.imm = 32'h0000_0000;
        else if (is_shift) b.imm = {27'd0, instr[24:20]};
        else b.imm = i_imm;
      end
      op_csr: b.imm = i_imm;
      default: b.illegal = 1'b1;
    endcase
    if (instr[11:7] == 5'd0) b.ctrl.load_regfile = 1'b0;
    return b;
  endfunction

  buf_state_t state_r;
  bundle_t    main_r;
  bundle_t    skid_r;
  logic       out_valid_r;
  logic       in_ready_r;
  bundle_t    dec_s;
  logic       accept_s;
  logic       pop_s;

  assign dec_s    = decode(in_instr, in_pc);
  assign accept_s = in_valid & in_ready_r;
  assign pop_s    = out_valid_r & out_ready;

  // Buffer occupancy FSM; flush outranks both accept and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (flush) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_r      <= dec_s;
            out_valid_r <= 1'b1;
            state_r     <= ONE;
          end
        end
        ONE: begin
          if (accept_s && !pop_s) begin
            skid_r     <= dec_s;
            in_ready_r <= 1'b0;
            state_r    <= FULL;
          end else if (accept_s) begin
            main_r <= dec_s;
          end else if (pop_s) begin
            out_valid_r <= 1'b0;
            state_r     <= EMPTY;
          end
        end
        FULL: begin
          if (pop_s) begin
            main_r     <= skid_r;
            in_ready_r <= 1'b1;
            state_r    <= ONE;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_ctrl    = main_r.ctrl;
  assign out_pc      = main_r.pc;
  assign out_imm     = main_r.imm;
  assign out_rs1     = main_r.rs1;
  assign out_rs2     = main_r.rs2;
  assign out_rd      = main_r.rd;
  assign out_illegal = main_r.illegal;

endmodule
